pdm_audio_path: RTL and testbench

PDM_AUDIO_PATH -- requirements
Module: pdm_audio_path

---
 rtl/audio_pkg.sv | 32 +++
 rtl/pdm_audio_path_if.sv | 28 ++
 rtl/pdm_sigma_delta.sv | 30 +++
 rtl/pdm_audio_path.sv | 195 +++++++++++++++++++
 tb/tb_pdm_audio_path.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the PDM audio path:
//   audio_state_e : capture/playback FSM states (IDLE, PRIME, RUN)
//   midscale()    : 1 << (width-1), the silent PCM level for unsigned samples
//   log2_decim()  : log2 of the (power-of-two) decimation ratio
// -----------------------------------------------------------------------------
package audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } audio_state_e;

    function automatic logic [63:0] midscale(input int unsigned width);
        return 64'd1 << (width - 32'd1);
    endfunction

    // Largest i with 2**i <= decim; exact for power-of-two ratios.
    function automatic int unsigned log2_decim(input int unsigned decim);
        int unsigned r;
        r = 32'd0;
        for (int unsigned i = 32'd1; i < 32'd32; i++) begin
            if ((32'd1 << i) <= decim) begin
                r = i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pdm_audio_path_if.sv
// -----------------------------------------------------------------------------
// pdm_audio_path_if
// Sample-buffer port of the PDM audio path.
//   wr_en / wr_addr / wr_data : one-cycle write strobe, address, PCM sample
//   rd_addr                   : playback read address
//   rd_data                   : read data, valid one cycle after rd_addr
// master = audio path, slave = buffer memory.
// -----------------------------------------------------------------------------
interface pdm_audio_path_if #(
    parameter int ADDR_W   = 16,
    parameter int SAMPLE_W = 16
);
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [SAMPLE_W-1:0] wr_data;
    logic [ADDR_W-1:0]   rd_addr;
    logic [SAMPLE_W-1:0] rd_data;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr,
        output rd_data
    );
endinterface

// File: rtl/pdm_sigma_delta.sv
// -----------------------------------------------------------------------------
// pdm_sigma_delta
// First-order sigma-delta modulator. Every cycle the residue (low SAMPLE_W
// bits) is added to the play sample; the carry bit is the 1-bit PDM output,
// so the density of ones equals play_sample / 2**SAMPLE_W.
//   clk, reset  : clock, synchronous active-high reset (clears accumulator)
//   play_sample : unsigned PCM sample to modulate
//   sd_bit      : modulator output bit (accumulator carry)
// -----------------------------------------------------------------------------
module pdm_sigma_delta #(
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] play_sample,
    output logic                sd_bit
);
    logic [SAMPLE_W:0] acc_r;

    // Accumulate sample into the residue; the previous carry is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r <= {(SAMPLE_W + 1){1'b0}};
        end else begin
            acc_r <= {1'b0, acc_r[SAMPLE_W-1:0]} + {1'b0, play_sample};
        end
    end

    assign sd_bit = acc_r[SAMPLE_W];
endmodule

// File: rtl/pdm_audio_path.sv
// -----------------------------------------------------------------------------
// pdm_audio_path
// Captures a PDM microphone stream into PCM samples (box-car decimation by
// DECIM), writes them to an external ring buffer, reads them back with a
// programmable lag and re-modulates them to PDM for the audio jack.
//   clk, reset : mic clock, synchronous active-high reset
//   en         : capture/playback enable (0 returns to IDLE)
//   wet        : 1 = modulated playback on pdm_out, 0 = dry pdm_in bypass
//   delay      : playback lag in samples (0 treated as 1)
//   pdm_in     : mic PDM data
//   buf_if     : buffer write/read port (master side)
//   sample_tick: one-cycle pulse per captured PCM sample
//   pdm_out    : registered PDM output
// Optional: define PDM_AUDIO_PATH_SYNC_EN to insert a 3-flop synchronizer on
// pdm_in (3 extra cycles of latency on capture and bypass).
// -----------------------------------------------------------------------------
module pdm_audio_path
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int ADDR_W   = 16,
    parameter int DECIM    = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              wet,
    input  logic [ADDR_W-1:0] delay,
    input  logic              pdm_in,
    pdm_audio_path_if.master  buf_if,
    output logic              sample_tick,
    output logic              pdm_out
);
    localparam int LOG2D = int'(log2_decim(DECIM));
    localparam int SHIFT = SAMPLE_W - LOG2D;
    localparam logic [SAMPLE_W-1:0] MID = SAMPLE_W'(midscale(SAMPLE_W));

    logic                pdm_s;
    logic [LOG2D-1:0]    win_cnt_r;
    logic [LOG2D:0]      ones_cnt_r;
    logic [LOG2D:0]      ones_sum_s;
    logic                win_last_s;
    logic [SAMPLE_W-1:0] scaled_s;
    logic [ADDR_W-1:0]   d_s;
    logic [ADDR_W:0]     wcnt_r;
    audio_state_e        state_r, state_n;
    logic                wr_en_r, tick_r;
    logic [ADDR_W-1:0]   wr_addr_r, rd_addr_r;
    logic [SAMPLE_W-1:0] wr_data_r, play_r;
    logic                rd_pend1_r, rd_pend2_r;
    logic                sd_s;
    logic                pdm_out_r;

`ifdef PDM_AUDIO_PATH_SYNC_EN
    logic [2:0] sync_r;

    // Three-flop synchronizer for the asynchronous mic data.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= 3'b000;
        end else begin
            sync_r <= {sync_r[1:0], pdm_in};
        end
    end

    assign pdm_s = sync_r[2];
`else
    assign pdm_s = pdm_in;
`endif

    assign ones_sum_s = ones_cnt_r + (LOG2D + 1)'(pdm_s);
    assign win_last_s = en && (win_cnt_r == LOG2D'(DECIM - 1));

    // Scale the ones count to full range; a full window saturates to all ones.
    always_comb begin
        scaled_s = {SAMPLE_W{1'b0}};
        if (ones_sum_s[LOG2D]) begin
            scaled_s = {SAMPLE_W{1'b1}};
        end else begin
            scaled_s = SAMPLE_W'(ones_sum_s[LOG2D-1:0]) << SHIFT;
        end
    end

    // Effective lag: never read the slot currently being written.
    always_comb begin
        d_s = delay;
        if (delay == {ADDR_W{1'b0}}) begin
            d_s = ADDR_W'(1'b1);
        end else begin
            d_s = delay;
        end
    end

    // Next-state logic; PRIME ends once d+1 samples are in the buffer.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (en) state_n = ST_PRIME;
                else    state_n = ST_IDLE;
            end
            ST_PRIME: begin
                if (!en)                                  state_n = ST_IDLE;
                else if (wr_en_r && (wcnt_r >= {1'b0, d_s})) state_n = ST_RUN;
                else                                      state_n = ST_PRIME;
            end
            ST_RUN: begin
                if (!en) state_n = ST_IDLE;
                else     state_n = ST_RUN;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Capture window, buffer write and read addressing.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt_r  <= {LOG2D{1'b0}};
            ones_cnt_r <= {(LOG2D + 1){1'b0}};
            wcnt_r     <= {(ADDR_W + 1){1'b0}};
            wr_en_r    <= 1'b0;
            tick_r     <= 1'b0;
            wr_addr_r  <= {ADDR_W{1'b0}};
            wr_data_r  <= {SAMPLE_W{1'b0}};
            rd_addr_r  <= {ADDR_W{1'b0}};
            rd_pend1_r <= 1'b0;
            rd_pend2_r <= 1'b0;
        end else begin
            if (!en) begin
                win_cnt_r  <= {LOG2D{1'b0}};
                ones_cnt_r <= {(LOG2D + 1){1'b0}};
                wcnt_r     <= {(ADDR_W + 1){1'b0}};
                wr_en_r    <= 1'b0;
                tick_r     <= 1'b0;
                wr_addr_r  <= {ADDR_W{1'b0}};
            end else begin
                // Power-of-two window: the counter wraps on its own.
                win_cnt_r  <= win_cnt_r + LOG2D'(1'b1);
                ones_cnt_r <= win_last_s ? {(LOG2D + 1){1'b0}} : ones_sum_s;
                wr_en_r    <= win_last_s;
                tick_r     <= win_last_s;
                if (win_last_s) wr_data_r <= scaled_s;
                if (wr_en_r)    wr_addr_r <= wr_addr_r + ADDR_W'(1'b1);
                if (wr_en_r && (state_r == ST_PRIME)) wcnt_r <= wcnt_r + (ADDR_W + 1)'(1'b1);
            end
            if (wr_en_r) rd_addr_r <= wr_addr_r - d_s;
            // Only reads issued in RUN feed playback; data lands two cycles later.
            rd_pend1_r <= wr_en_r && (state_n == ST_RUN);
            rd_pend2_r <= rd_pend1_r;
        end
    end

    // Play sample: midscale until RUN, then each lagged buffer read.
    always_ff @(posedge clk) begin
        if (reset) begin
            play_r <= MID;
        end else if (state_r != ST_RUN) begin
            play_r <= MID;
        end else if (rd_pend2_r) begin
            play_r <= buf_if.rd_data;
        end
    end

    pdm_sigma_delta #(.SAMPLE_W(SAMPLE_W)) u_sd (
        .clk         (clk),
        .reset       (reset),
        .play_sample (play_r),
        .sd_bit      (sd_s)
    );

    // Output select: modulated playback or dry bypass.
    always_ff @(posedge clk) begin
        if (reset) begin
            pdm_out_r <= 1'b0;
        end else begin
            pdm_out_r <= wet ? sd_s : pdm_s;
        end
    end

    assign buf_if.wr_en   = wr_en_r;
    assign buf_if.wr_addr = wr_addr_r;
    assign buf_if.wr_data = wr_data_r;
    assign buf_if.rd_addr = rd_addr_r;
    assign sample_tick    = tick_r;
    assign pdm_out        = pdm_out_r;
endmodule

// File: tb/tb_pdm_audio_path.sv
// -----------------------------------------------------------------------------
// tb_pdm_audio_path
// Directed bench for pdm_audio_path (SAMPLE_W=16, ADDR_W=4, DECIM=64) with a
// behavioural reference model and a small ring-buffer memory.
// -----------------------------------------------------------------------------
module tb_pdm_audio_path;
    localparam int SW = 16;
    localparam int AW = 4;
    localparam int DC = 64;
`ifdef PDM_AUDIO_PATH_SYNC_EN
    localparam int SYNC_LAT = 3;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          reset, en, wet, pdm_in;
    logic [AW-1:0] delay;
    logic          sample_tick, pdm_out;

    pdm_audio_path_if #(.ADDR_W(AW), .SAMPLE_W(SW)) bus ();

    pdm_audio_path #(.SAMPLE_W(SW), .ADDR_W(AW), .DECIM(DC)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .wet         (wet),
        .delay       (delay),
        .pdm_in      (pdm_in),
        .buf_if      (bus),
        .sample_tick (sample_tick),
        .pdm_out     (pdm_out)
    );

    always #5 clk = ~clk;

    // ---------------- buffer memory ----------------
    logic [SW-1:0] mem [0:15];
    logic          clear_mem, force_rd;
    logic [SW-1:0] force_val;

    always @(posedge clk) begin
        if (clear_mem) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'h0000;
        end else if (bus.wr_en === 1'b1) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
        bus.rd_data <= force_rd ? force_val : mem[bus.rd_addr];
    end

    // ---------------- bookkeeping ----------------
    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- pdm_in pattern driver ----------------
    int pat = 0;   // 0 zeros, 1 ones, 2 alternate, 3 one-in-four, 4 random
    int pcnt = 0;
    initial begin
        pdm_in = 1'b0;
        forever begin
            @(negedge clk);
            pcnt++;
            case (pat)
                0: pdm_in = 1'b0;
                1: pdm_in = 1'b1;
                2: pdm_in = ~pdm_in;
                3: pdm_in = ((pcnt % 4) == 0);
                default: pdm_in = 1'($urandom_range(1, 0));
            endcase
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    bit            q[$];
    logic [3:0]    hist;
    logic          s_rst, s_en, s_pdm, s_wet, pe;
    logic [AW-1:0] s_dly, m_addr, m_rd;
    logic          exp_wr, exp_pdm, pdm_chk, armed;
    logic [SW-1:0] exp_data;
    int            ones, v;

    initial begin
        armed = 1'b0; hist = 4'h0; exp_wr = 1'b0; m_addr = 4'h0; m_rd = 4'h0;
        exp_pdm = 1'b0; pdm_chk = 1'b0; exp_data = 16'h0000;
        forever begin
            @(posedge clk);
            s_rst = reset; s_en = en; s_pdm = pdm_in; s_wet = wet; s_dly = delay;
            @(negedge clk);
            pe = (SYNC_LAT == 0) ? s_pdm : hist[(SYNC_LAT == 0) ? 0 : SYNC_LAT - 1];
            if (s_rst) begin
                hist = 4'h0; q.delete(); exp_wr = 1'b0; m_addr = 4'h0; m_rd = 4'h0;
                exp_pdm = 1'b0; pdm_chk = 1'b1; armed = 1'b1;
            end else begin
                hist = {hist[2:0], s_pdm};
                if (exp_wr) begin
                    m_rd   = m_addr - ((s_dly == 4'h0) ? 4'h1 : s_dly);
                    m_addr = m_addr + 4'h1;
                end
                if (!s_en) m_addr = 4'h0;
                exp_wr = 1'b0;
                if (!s_en) begin
                    q.delete();
                end else begin
                    q.push_back(pe);
                    if (q.size() == DC) begin
                        ones = 0;
                        foreach (q[i]) ones += int'(q[i]);
                        v = ones * (1 << SW) / DC;
                        if (v > (1 << SW) - 1) v = (1 << SW) - 1;
                        exp_data = v[SW-1:0];
                        exp_wr = 1'b1;
                        q.delete();
                    end
                end
                pdm_chk = !s_wet;
                exp_pdm = pe;
            end
            if (armed) begin
                check("wr_en", bus.wr_en, exp_wr);
                check("sample_tick", sample_tick, exp_wr);
                check("wr_addr", bus.wr_addr, m_addr);
                check("rd_addr", bus.rd_addr, m_rd);
                if (exp_wr)  check("wr_data", bus.wr_data, exp_data);
                if (pdm_chk) check("pdm_out", pdm_out, exp_pdm);
            end
        end
    end

    // ---------------- directed helpers ----------------
    longint last_wr_t;

    task automatic wait_wr(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.wr_en !== 1'b1 && k < 200);
        if (k >= 200) check({name, " timeout"}, 32'd0, 32'd1);
        last_wr_t = $time;
    endtask

    task automatic count_ones(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            c += int'(pdm_out);
        end
    endtask

    // Global guard against a hung run.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed scenarios ----------------
    logic [SW-1:0] scale_lit [3];
    int            scale_pat [3];
    longint        t0;
    int            c, f, errs;
    logic          bits [64];

    initial begin
        scale_lit = '{16'hFFFF, 16'h0000, 16'h8000};
        scale_pat = '{1, 0, 2};
        reset = 1'b1; en = 1'b0; wet = 1'b1; delay = 4'd1;
        force_rd = 1'b0; force_val = 16'h0000; clear_mem = 1'b0;
        repeat (2) @(negedge clk);
        check("rst wr_en", bus.wr_en, 1'b0);
        check("rst sample_tick", sample_tick, 1'b0);
        check("rst pdm_out", pdm_out, 1'b0);
        check("rst wr_addr", bus.wr_addr, 4'h0);
        check("rst rd_addr", bus.rd_addr, 4'h0);
        check("rst wr_data", bus.wr_data, 16'h0000);
        reset = 1'b0; en = 1'b1;

        // Capture scaling and write cadence.
        for (int p = 0; p < 3; p++) begin
            pat = scale_pat[p];
            wait_wr("scale");
            wait_wr("scale");
            t0 = last_wr_t;
            check("scale wr_data", bus.wr_data, scale_lit[p]);
            wait_wr("cadence");
            check("cadence", 32'((last_wr_t - t0) / 10), 32'd64);
        end

        // Address wrap over 17 windows.
        pat = 3;
        en = 1'b0;
        repeat (2) @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wait_wr("wrap");
            check("wrap wr_addr", bus.wr_addr, 32'(i % 16));
        end

        // Priming with delay=3, then with delay=0 (acts as 1).
        for (int t = 0; t < 2; t++) begin
            pat = 1;
            en = 1'b0;
            clear_mem = 1'b1;
            @(negedge clk);
            clear_mem = 1'b0;
            delay = (t == 0) ? 4'd3 : 4'd0;
            @(negedge clk);
            en = 1'b1;
            repeat ((t == 0) ? 3 : 1) wait_wr("prime");
            repeat (3) @(negedge clk);
            count_ones(56, c);
            check("prime midscale ones", c, 32'd28);
            wait_wr("prime last");
            @(negedge clk);
            check("first run rd_addr", bus.rd_addr, 4'h0);
            repeat (3) @(negedge clk);
            count_ones(56, c);
            check("run full-scale ones>=55", (c >= 55), 1'b1);
        end

        // Modulator density with forced play samples.
        force_val = 16'h4000;
        force_rd = 1'b1;
        wait_wr("density");
        repeat (6) @(negedge clk);
        c = 0;
        for (int j = 0; j < 64; j++) begin
            @(negedge clk);
            bits[j] = pdm_out;
            c += int'(pdm_out);
        end
        check("density 0x4000", c, 32'd16);
        f = 0;
        while (f < 3 && bits[f] !== 1'b1) f++;
        errs = 0;
        for (int j = 0; j < 64; j++)
            if (bits[j] !== ((j >= f) && (((j - f) % 4) == 0))) errs++;
        check("period4 errors", errs, 32'd0);
        force_val = 16'hC000;
        wait_wr("density");
        repeat (6) @(negedge clk);
        count_ones(64, c);
        check("density 0xC000", c, 32'd48);
        force_rd = 1'b0;

        // Reset mid-window while in RUN.
        wait_wr("pre-reset");
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid rst wr_en", bus.wr_en, 1'b0);
        check("mid rst sample_tick", sample_tick, 1'b0);
        check("mid rst pdm_out", pdm_out, 1'b0);
        check("mid rst wr_addr", bus.wr_addr, 4'h0);
        check("mid rst rd_addr", bus.rd_addr, 4'h0);
        check("mid rst wr_data", bus.wr_data, 16'h0000);
        reset = 1'b0;
        t0 = $time;
        wait_wr("post-reset");
        check("post-reset first write", 32'((last_wr_t - t0) / 10), 32'd64);
        repeat (3) @(negedge clk);
        count_ones(56, c);
        check("post-reset prime ones", c, 32'd28);

        // Dry bypass; capture cadence must be unaffected.
        wet = 1'b0;
        pat = 4;
        wait_wr("bypass");
        t0 = last_wr_t;
        wait_wr("bypass");
        check("bypass cadence", 32'((last_wr_t - t0) / 10), 32'd64);
        pat = 1;
        repeat (SYNC_LAT + 3) @(negedge clk);
        check("bypass high", pdm_out, 1'b1);
        pat = 0;
        repeat (SYNC_LAT + 3) @(negedge clk);
        check("bypass low", pdm_out, 1'b0);

        en = 1'b0;
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
